pixel_reader: RTL and testbench
===============================

# pixel_reader

Read-side counterpart of the graphics memory path. It fetches one 256-pixel scanline (64 × 32-bit words, 8-bit RGB per pixel) from graphics memory over the memory controller's command and read-FIFO port into a double line buffer. It serves single pixels from that buffer to the video output stage. It sits between the memory controller read port and the VGA timing/scan logic.

## Interface
Parameters:
- SCREEN_LINES, default 192: number of valid scanlines; requests for lines at or above this value are acknowledged without any memory access.

Ports (clock and reset first):
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- calib_done  in  1  memory calibration complete; line requests are refused while low.
- line_req  in  1  single-cycle pulse requesting a fetch of line line_y.
- line_y  in  8  line to fetch; it also selects the target buffer through line_y[0].
- line_busy  out  1  high from request acceptance through line_done.
- line_done  out  1  single-cycle pulse when the line buffer is filled.
- pixel_x  in  8  pixel column to read.
- pixel_y0  in  1  selects the buffer to read from.
- pixel_rgb  out  8  registered pixel value.
- rd_error  out  1  sticky flag, set by mem_rd_overflow or mem_rd_error.
- mem_cmd_en  out  1  memory command strobe.
- mem_cmd_instr  out  3  constant 3'b001 (read).
- mem_cmd_bl  out  6  burst length minus 1.
- mem_cmd_byte_addr  out  30  command byte address.
- mem_cmd_full  in  1  command FIFO full.
- mem_rd_en  out  1  read-FIFO pop.
- mem_rd_data  in  32  read-FIFO head word (first-word fall-through).
- mem_rd_empty  in  1  read FIFO empty.
- mem_rd_count  in  7  read FIFO occupancy; informational, not used for control.
- mem_rd_overflow  in  1  read FIFO overflow.
- mem_rd_error  in  1  read FIFO error.

## Operation
- Storage: two buffers of 64 words × 32 bits. Buffer b holds the lines with y[0] = b.
- States:
  - IDLE: mem_rd_en = !mem_rd_empty. Stale words are discarded.
  - Request acceptance in IDLE requires line_req && calib_done && mem_rd_empty. On acceptance, latch line_y, assert line_busy, and go to CMD.
  - If the latched line_y >= SCREEN_LINES, skip memory: pulse line_done and return to IDLE. The buffer is unchanged.
  - CMD: wait while mem_cmd_full. Otherwise assert mem_cmd_en for exactly one cycle with mem_cmd_bl = 6'd63 and mem_cmd_byte_addr = {GRAPHICS_MEM_PREFIX, line, 8'h00}. Clear word_index to 0 and go to READ.
  - READ: mem_rd_en = !mem_rd_empty (combinational). On each pop, write mem_rd_data to buffer[line[0]][word_index] and increment word_index. On the pop with word_index == 63, pulse line_done the next cycle, deassert line_busy, and go to IDLE.
- line_req while line_busy is ignored and never queued.
- Byte lanes: pixel x is stored in word x[7:2], bits [8·x[1:0]+7 : 8·x[1:0]]. This matches the write-side mask convention, where byte 0 holds x[1:0] = 0.
- Pixel port: pixel_rgb <= byte(buffer[pixel_y0][pixel_x[7:2]], pixel_x[1:0]), updated every cycle.
  - Reading a buffer while it is being filled returns mixed old and new data; no hazard protection is provided.
- rd_error: set on any cycle where mem_rd_overflow or mem_rd_error is high. It clears only on rst.

## Timing
- Reset values:
  - mem_cmd_en = 0, mem_cmd_bl = 0, mem_cmd_byte_addr = {GRAPHICS_MEM_PREFIX, 16'h0000}.
  - line_busy = 0, line_done = 0, pixel_rgb = 0, rd_error = 0.
  - State is IDLE and word_index = 0. Buffer contents are not reset.
- mem_rd_en is low during rst.
- rst mid-fetch: abandon the fetch and do not pulse line_done. Words still arriving for the abandoned burst are drained in IDLE; the mem_rd_empty acceptance condition blocks a new request until the drain completes.
- Latency with an idle controller: request accepted at cycle 0, mem_cmd_en at cycle 1. line_done arrives 1 cycle after the 64th pop, for a minimum of 66 cycles after mem_cmd_en. An out-of-range line gives line_done at cycle 1.
- Pixel read latency: 1 cycle from pixel_x/pixel_y0 to pixel_rgb.
- A pop and the arrival of the next word in the same cycle are allowed. There are no bubbles when the FIFO stays non-empty.

## Test plan
- Fetch line 5: preload memory line 5 with word i = {4{i[7:0]}}. Pulse line_req with line_y = 5 → one mem_cmd_en with addr {prefix, 8'd5, 8'h00} and bl = 63. Then 64 pops, a single line_done, and pixel_y0 = 1, pixel_x = 0x2D gives pixel_rgb = 0x0B one cycle later.
- Byte lanes: word 0 = 32'h44332211 → pixel_x 0..3 read 0x11, 0x22, 0x33, 0x44.
- Backpressure: hold mem_cmd_full for 10 cycles → mem_cmd_en is delayed and is still a single pulse. Random mem_rd_empty gaps → exactly 64 pops, with data in the correct word order.
- Gating: line_req with calib_done = 0 → ignored. A second line_req while busy → ignored. line_y = 192 → line_done at cycle 1 with no mem_cmd_en.
- Reset at word 30: assert rst, then release with 34 words still arriving → all 34 drained, no line_done. A subsequent line_req is accepted only once mem_rd_empty is high.
- Error: pulse mem_rd_overflow for one cycle → rd_error stays high until rst.

Source files
------------

// File: rtl/pixel_reader.sv
// pixel_reader
// Fetches one 256-pixel scanline (64 x 32-bit words) from graphics memory
// through the memory controller command / read-FIFO port into one half of a
// double line buffer, and serves single 8-bit pixels from either half to the
// video output stage with one cycle of latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fetch in flight; any stale read-FIFO words are drained
// CMD   | line latched; skip if off-screen, else issue the read command
// READ  | popping 64 burst words into buffer[line[0]]

module pixel_reader #(
    parameter int unsigned SCREEN_LINES        = 192,
    parameter logic [13:0] GRAPHICS_MEM_PREFIX = 14'h0010
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        calib_done,
    input  logic        line_req,
    input  logic [7:0]  line_y,
    output logic        line_busy,
    output logic        line_done,

    input  logic [7:0]  pixel_x,
    input  logic        pixel_y0,
    output logic [7:0]  pixel_rgb,

    output logic        rd_error,

    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,

    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_empty,
    input  logic [6:0]  mem_rd_count,
    input  logic        mem_rd_overflow,
    input  logic        mem_rd_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        READ = 2'd2
    } state_t;

    localparam logic [5:0] LAST_WORD = 6'd63;

    state_t      state;
    logic [7:0]  line_q;
    logic [5:0]  word_index;
    logic        line_off_screen;
    logic        fill_word;

    // Two 64-word halves: address bit 6 is the buffer, i.e. the line parity.
    logic [31:0] line_buf [0:127];
    logic [31:0] rd_word;

    // Occupancy is informational only; flow control uses the empty flag.
    logic        unused_rd_count;
    assign unused_rd_count = ^mem_rd_count;

    assign mem_cmd_instr = 3'b001;

    // Off-screen lines are acknowledged without touching memory.
    assign line_off_screen = (32'(line_q) >= SCREEN_LINES);

    // The FIFO is popped whenever it has data in IDLE (draining leftovers of
    // an abandoned burst) or in READ (filling the buffer). Never during reset.
    always_comb begin
        mem_rd_en = 1'b0;
        if (!rst && !mem_rd_empty && (state == IDLE || state == READ))
            mem_rd_en = 1'b1;
    end

    // Only pops taken in READ land in the buffer; IDLE pops are discarded.
    assign fill_word = mem_rd_en && (state == READ);

    // Sequencer: request acceptance, command issue, burst word counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            line_q            <= 8'd0;
            word_index        <= 6'd0;
            line_busy         <= 1'b0;
            line_done         <= 1'b0;
            mem_cmd_en        <= 1'b0;
            mem_cmd_bl        <= 6'd0;
            mem_cmd_byte_addr <= {GRAPHICS_MEM_PREFIX, 16'h0000};
        end else begin
            line_done  <= 1'b0;
            mem_cmd_en <= 1'b0;
            case (state)
                IDLE: begin
                    // An empty FIFO guarantees no leftovers mix into the new line.
                    if (line_req && calib_done && mem_rd_empty) begin
                        line_q    <= line_y;
                        line_busy <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (line_off_screen) begin
                        line_done <= 1'b1;
                        line_busy <= 1'b0;
                        state     <= IDLE;
                    end else if (!mem_cmd_full) begin
                        mem_cmd_en        <= 1'b1;
                        mem_cmd_bl        <= LAST_WORD;
                        mem_cmd_byte_addr <= {GRAPHICS_MEM_PREFIX, line_q, 8'h00};
                        word_index        <= 6'd0;
                        state             <= READ;
                    end
                end
                READ: begin
                    if (mem_rd_en) begin
                        word_index <= word_index + 6'd1;
                        if (word_index == LAST_WORD) begin
                            line_done <= 1'b1;
                            line_busy <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer fill; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_word)
            line_buf[{line_q[0], word_index}] <= mem_rd_data;
    end

    assign rd_word = line_buf[{pixel_y0, pixel_x[7:2]}];

    // Pixel port: byte lane x[1:0] of word x[7:2], lane 0 in the low byte.
    // No interlock against a concurrent fill of the same half.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_rgb <= 8'd0;
        end else begin
            case (pixel_x[1:0])
                2'd0:    pixel_rgb <= rd_word[7:0];
                2'd1:    pixel_rgb <= rd_word[15:8];
                2'd2:    pixel_rgb <= rd_word[23:16];
                default: pixel_rgb <= rd_word[31:24];
            endcase
        end
    end

    // Sticky read-path error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            rd_error <= 1'b0;
        else if (mem_rd_overflow || mem_rd_error)
            rd_error <= 1'b1;
    end

endmodule

// File: tb/tb_pixel_reader.sv
// Directed testbench for pixel_reader with a small memory-controller model:
// a command accepted on mem_cmd_en queues 64 words of that line into a
// first-word-fall-through read FIFO, optionally with random arrival gaps.

module tb_pixel_reader;

    localparam logic [13:0] PFX = 14'h0010;

    logic        clk;
    logic        rst;
    logic        calib_done;
    logic        line_req;
    logic [7:0]  line_y;
    logic        line_busy;
    logic        line_done;
    logic [7:0]  pixel_x;
    logic        pixel_y0;
    logic [7:0]  pixel_rgb;
    logic        rd_error;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_empty;
    logic [6:0]  mem_rd_count;
    logic        mem_rd_overflow;
    logic        mem_rd_error;

    pixel_reader #(
        .SCREEN_LINES(192),
        .GRAPHICS_MEM_PREFIX(PFX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .calib_done       (calib_done),
        .line_req         (line_req),
        .line_y           (line_y),
        .line_busy        (line_busy),
        .line_done        (line_done),
        .pixel_x          (pixel_x),
        .pixel_y0         (pixel_y0),
        .pixel_rgb        (pixel_rgb),
        .rd_error         (rd_error),
        .mem_cmd_en       (mem_cmd_en),
        .mem_cmd_instr    (mem_cmd_instr),
        .mem_cmd_bl       (mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr),
        .mem_cmd_full     (mem_cmd_full),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_empty     (mem_rd_empty),
        .mem_rd_count     (mem_rd_count),
        .mem_rd_overflow  (mem_rd_overflow),
        .mem_rd_error     (mem_rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents: line 5 is {4{i}}, line 6 word 0 is a byte-lane
    // pattern, everything else is {line, i, ~line, i}.
    function automatic logic [31:0] gen_word(input logic [7:0] ln, input int i);
        logic [7:0] b;
        b = 8'(i);
        if (ln == 8'd5)
            return {b, b, b, b};
        if (ln == 8'd6 && i == 0)
            return 32'h44332211;
        return {ln, b, ~ln, b};
    endfunction

    logic [31:0] rdq[$];
    int          pend    = 0;
    int          m_widx  = 0;
    logic [7:0]  m_line  = 8'd0;
    bit          gap_mode = 1'b0;
    int          pop_cnt = 0;
    int          cmd_cnt = 0;
    int          done_cnt = 0;

    initial begin
        mem_rd_empty = 1'b1;
        mem_rd_data  = 32'h0;
    end
    assign mem_rd_count = 7'(rdq.size());

    // Controller model: pops and pushes happen on the edge; the visible
    // FIFO head/empty update with nonblocking assignment like real flops.
    always @(posedge clk) begin
        if (mem_rd_en && rdq.size() > 0) begin
            void'(rdq.pop_front());
            pop_cnt++;
        end
        if (mem_cmd_en) begin
            m_line = mem_cmd_byte_addr[15:8];
            pend   = 64;
            m_widx = 0;
        end else if (pend > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
            rdq.push_back(gen_word(m_line, m_widx));
            m_widx++;
            pend--;
        end
        mem_rd_empty <= (rdq.size() == 0);
        mem_rd_data  <= (rdq.size() > 0) ? rdq[0] : 32'h0;
    end

    always @(negedge clk) begin
        if (mem_cmd_en) cmd_cnt++;
        if (line_done)  done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic [7:0] y);
        line_y   = y;
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int i = 0;
        while (!line_done && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk(tag, line_done, 1);
    endtask

    task automatic wait_cmd(input string tag, input int limit);
        int i = 0;
        while (!mem_cmd_en && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk(tag, mem_cmd_en, 1);
    endtask

    task automatic pix(input string tag, input logic y0, input logic [7:0] x, input logic [7:0] exp);
        pixel_y0 = y0;
        pixel_x  = x;
        tick(1);
        chk(tag, pixel_rgb, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, p0, i;
        logic [7:0] lane_exp [4];
        lane_exp[0] = 8'h11;
        lane_exp[1] = 8'h22;
        lane_exp[2] = 8'h33;
        lane_exp[3] = 8'h44;

        rst = 1'b1; calib_done = 1'b1; line_req = 1'b0; line_y = 8'd0;
        pixel_x = 8'd0; pixel_y0 = 1'b0; mem_cmd_full = 1'b0;
        mem_rd_overflow = 1'b0; mem_rd_error = 1'b0;
        tick(3);

        chk("rst_busy",   line_busy, 0);
        chk("rst_done",   line_done, 0);
        chk("rst_cmd_en", mem_cmd_en, 0);
        chk("rst_bl",     mem_cmd_bl, 0);
        chk("rst_addr",   mem_cmd_byte_addr, {PFX, 16'h0000});
        chk("rst_rgb",    pixel_rgb, 0);
        chk("rst_err",    rd_error, 0);
        chk("rst_rd_en",  mem_rd_en, 0);
        chk("instr",      mem_cmd_instr, 3'b001);
        rst = 1'b0;
        tick(2);

        // Fetch line 5 into buffer 1
        c0 = cmd_cnt; d0 = done_cnt; p0 = pop_cnt;
        req(8'd5);
        chk("l5_busy",      line_busy, 1);
        chk("l5_cmd_early", mem_cmd_en, 0);
        tick(1);
        chk("l5_cmd_lat",   mem_cmd_en, 1);
        chk("l5_addr",      mem_cmd_byte_addr, {PFX, 8'd5, 8'h00});
        chk("l5_bl",        mem_cmd_bl, 6'd63);
        tick(1);
        chk("l5_cmd_pulse", mem_cmd_en, 0);
        wait_done("l5_done", 300);
        tick(3);
        chk("l5_pops",   pop_cnt - p0, 64);
        chk("l5_cmds",   cmd_cnt - c0, 1);
        chk("l5_dones",  done_cnt - d0, 1);
        chk("l5_idle",   line_busy, 0);
        pix("l5_px2d", 1'b1, 8'h2D, 8'h0B);
        pix("l5_pxff", 1'b1, 8'hFF, 8'h3F);

        // Line 6 into buffer 0 with command backpressure and FIFO gaps
        mem_cmd_full = 1'b1;
        gap_mode = 1'b1;
        c0 = cmd_cnt; d0 = done_cnt; p0 = pop_cnt;
        req(8'd6);
        tick(10);
        chk("bp_held_cmd", cmd_cnt - c0, 0);
        chk("bp_busy",     line_busy, 1);
        mem_cmd_full = 1'b0;
        wait_cmd("bp_cmd", 10);
        chk("bp_addr", mem_cmd_byte_addr, {PFX, 8'd6, 8'h00});
        wait_done("bp_done", 800);
        tick(3);
        gap_mode = 1'b0;
        chk("bp_pops",  pop_cnt - p0, 64);
        chk("bp_cmds",  cmd_cnt - c0, 1);
        chk("bp_dones", done_cnt - d0, 1);
        for (int x = 0; x < 4; x++)
            pix("lane", 1'b0, 8'(x), lane_exp[x]);
        pix("l6_px25", 1'b0, 8'h25, 8'hF9);
        pix("l6_pxc4", 1'b0, 8'hC4, 8'h31);
        pix("l5_kept", 1'b1, 8'h2D, 8'h0B);

        // Refused while calibration is pending
        calib_done = 1'b0;
        c0 = cmd_cnt;
        req(8'd7);
        tick(3);
        chk("calib_busy", line_busy, 0);
        chk("calib_cmds", cmd_cnt - c0, 0);
        calib_done = 1'b1;

        // Second request while busy is dropped
        c0 = cmd_cnt; d0 = done_cnt;
        req(8'd9);
        tick(2);
        req(8'd11);
        wait_done("busy_done", 300);
        tick(5);
        chk("busy_cmds",  cmd_cnt - c0, 1);
        chk("busy_dones", done_cnt - d0, 1);
        chk("busy_line",  m_line, 8'd9);
        chk("busy_idle",  line_busy, 0);
        pix("l9_px01", 1'b1, 8'h01, 8'hF6);

        // Off-screen line: done at cycle 1, no memory command
        c0 = cmd_cnt; d0 = done_cnt;
        req(8'd192);
        chk("oob_busy", line_busy, 1);
        tick(1);
        chk("oob_done", line_done, 1);
        chk("oob_cmd",  mem_cmd_en, 0);
        tick(2);
        chk("oob_cmds",  cmd_cnt - c0, 0);
        chk("oob_dones", done_cnt - d0, 1);
        chk("oob_idle",  line_busy, 0);
        pix("oob_buf", 1'b0, 8'h00, 8'h11);

        // Reset in the middle of a burst, then drain
        d0 = done_cnt; p0 = pop_cnt;
        req(8'd13);
        i = 0;
        while (pop_cnt - p0 < 30 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("mid_reach30", pop_cnt - p0, 30);
        rst = 1'b1;
        tick(3);
        chk("mid_rd_en_rst", mem_rd_en, 0);
        rst = 1'b0;
        line_y = 8'd15;
        line_req = 1'b1;
        tick(1);
        line_req = 1'b0;
        chk("mid_req_blocked", line_busy, 0);
        i = 0;
        while ((pend > 0 || rdq.size() > 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        tick(2);
        chk("mid_drained", pop_cnt - p0 - 30, 34);
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_idle",    line_busy, 0);
        c0 = cmd_cnt;
        req(8'd15);
        chk("mid_accept", line_busy, 1);
        wait_done("mid_next_done", 300);
        tick(2);
        chk("mid_next_cmds", cmd_cnt - c0, 1);
        pix("l15_px01", 1'b1, 8'h01, 8'hF0);

        // Sticky error flag
        mem_rd_overflow = 1'b1;
        tick(1);
        mem_rd_overflow = 1'b0;
        tick(5);
        chk("err_ovf_sticky", rd_error, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("err_cleared", rd_error, 0);
        mem_rd_error = 1'b1;
        tick(1);
        mem_rd_error = 1'b0;
        tick(3);
        chk("err_rd_sticky", rd_error, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
